// File: rtl/spi_master_drive_pkg.sv
// Shared SPI/FLASH definitions: engine state encoding, bus mode and FLASH opcodes.
// Imported by the byte engine and by the FLASH command/read controllers above it.
package spi_master_drive_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SETUP = 3'd1,
    ST_SHIFT = 3'd2,
    ST_LOAD  = 3'd3,
    ST_HOLD  = 3'd4
  } spi_state_e;

  // {CPOL, CPHA}
  localparam logic [1:0] SPI_MODE0 = 2'b00;

  localparam logic [7:0] FLASH_READ      = 8'h03;
  localparam logic [7:0] FLASH_FAST_READ = 8'h0B;
  localparam logic [7:0] FLASH_WREN      = 8'h06;
  localparam logic [7:0] FLASH_WRDI      = 8'h04;
  localparam logic [7:0] FLASH_RDSR      = 8'h05;
  localparam logic [7:0] FLASH_PP        = 8'h02;
  localparam logic [7:0] FLASH_SE        = 8'hD8;
  localparam logic [7:0] FLASH_BE        = 8'hC7;
  localparam logic [7:0] FLASH_RDID      = 8'h9F;

endpackage

// File: rtl/spi_master_drive_if.sv
// Byte-level request/response bus between a FLASH controller (master) and the SPI engine (slave).
interface spi_master_drive_if;

  logic       spi_start;
  logic       spi_end;
  logic [7:0] data_send;
  logic [7:0] data_rec;
  logic       send_done;
  logic       rec_done;
  logic       busy;

  modport master (
    output spi_start, spi_end, data_send,
    input  data_rec, send_done, rec_done, busy
  );

  modport slave (
    input  spi_start, spi_end, data_send,
    output data_rec, send_done, rec_done, busy
  );

endinterface

// File: rtl/spi_master_drive_sclk_gen.sv
// SCLK divider: counts CLK_DIV cycles per phase while running, toggles SCLK only when shifting.
// Strobes are combinational and mark the sys_clk edge on which SCLK changes.
module spi_master_drive_sclk_gen #(
  parameter int CLK_DIV = 2
) (
  input  logic sys_clk,
  input  logic sys_rst_n,
  input  logic i_run,
  input  logic i_toggle,
  output logic o_sclk,
  output logic o_tick,
  output logic o_rise,
  output logic o_fall
);

  localparam int DIV_W = $clog2(CLK_DIV + 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  logic [DIV_W-1:0] r_div_cnt;
  logic             r_sclk;
  logic             w_tick;

  assign w_tick = i_run && (r_div_cnt == DIV_LAST);
  assign o_tick = w_tick;
  assign o_rise = w_tick && i_toggle && !r_sclk;
  assign o_fall = w_tick && i_toggle && r_sclk;
  assign o_sclk = r_sclk;

  // Counter parks at zero outside SETUP/SHIFT/HOLD so every phase starts a full period.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_div_cnt <= '0;
      r_sclk    <= 1'b0;
    end else begin
      if (!i_run || w_tick) begin
        r_div_cnt <= '0;
      end else begin
        r_div_cnt <= r_div_cnt + 1'b1;
      end
      if (!i_toggle) begin
        r_sclk <= 1'b0;
      end else if (w_tick) begin
        r_sclk <= !r_sclk;
      end
    end
  end

endmodule

// File: rtl/spi_master_drive.sv
// SPI mode-0 master byte engine for serial FLASH: streams MSB-first bytes between start and end pulses.
// One send_done/rec_done strobe per byte; a one-cycle LOAD slot fetches the next byte without SCLK gaps.
module spi_master_drive
  import spi_master_drive_pkg::*;
#(
  parameter int CLK_DIV = 2
) (
  input  logic              sys_clk,
  input  logic              sys_rst_n,
  spi_master_drive_if.slave bus,
  output logic              o_spi_cs_n,
  output logic              o_spi_sclk,
  output logic              o_spi_mosi,
  input  logic              i_spi_miso
);

  spi_state_e r_state;
  logic [7:0] r_tx_sr;
  logic [7:0] r_rx_sr;
  logic [2:0] r_bit_cnt;
  logic       r_end_pend;
  logic       r_cs_n;
  logic       r_mosi;
  logic [7:0] r_data_rec;
  logic       r_send_done;
  logic       r_rec_done;
  logic       r_busy;

  logic w_run;
  logic w_toggle;
  logic w_tick;
  logic w_rise;
  logic w_fall;
  logic w_sclk;

  assign w_run    = (r_state == ST_SETUP) || (r_state == ST_SHIFT) || (r_state == ST_HOLD);
  assign w_toggle = (r_state == ST_SHIFT);

  spi_master_drive_sclk_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_sclk_gen (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .i_run     (w_run),
    .i_toggle  (w_toggle),
    .o_sclk    (w_sclk),
    .o_tick    (w_tick),
    .o_rise    (w_rise),
    .o_fall    (w_fall)
  );

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_state     <= ST_IDLE;
      r_tx_sr     <= '0;
      r_rx_sr     <= '0;
      r_bit_cnt   <= '0;
      r_end_pend  <= 1'b0;
      r_cs_n      <= 1'b1;
      r_mosi      <= 1'b0;
      r_data_rec  <= '0;
      r_send_done <= 1'b0;
      r_rec_done  <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_send_done <= 1'b0;
      r_rec_done  <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (bus.spi_start) begin
            r_state    <= ST_SETUP;
            r_cs_n     <= 1'b0;
            r_tx_sr    <= bus.data_send;
            r_mosi     <= bus.data_send[7];
            r_bit_cnt  <= '0;
            r_end_pend <= 1'b0;
            r_busy     <= 1'b1;
          end
        end
        ST_SETUP: begin
          if (bus.spi_end) r_end_pend <= 1'b1;
          if (w_tick) r_state <= ST_SHIFT;
        end
        ST_SHIFT: begin
          if (bus.spi_end) r_end_pend <= 1'b1;
          if (w_rise) r_rx_sr <= {r_rx_sr[6:0], i_spi_miso};
          if (w_fall) begin
            r_bit_cnt <= r_bit_cnt + 3'd1;
            // Last fall closes the byte; MOSI keeps bit 0 until LOAD decides what follows.
            if (r_bit_cnt == 3'd7) begin
              r_data_rec  <= r_rx_sr;
              r_send_done <= 1'b1;
              r_rec_done  <= 1'b1;
              r_state     <= ST_LOAD;
            end else begin
              r_mosi  <= r_tx_sr[6];
              r_tx_sr <= {r_tx_sr[6:0], 1'b0};
            end
          end
        end
        ST_LOAD: begin
          if (bus.spi_end || r_end_pend) begin
            r_state <= ST_HOLD;
          end else begin
            r_tx_sr <= bus.data_send;
            r_mosi  <= bus.data_send[7];
            r_state <= ST_SHIFT;
          end
        end
        ST_HOLD: begin
          if (w_tick) begin
            r_cs_n  <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= ST_IDLE;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_cs_n  <= 1'b1;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.data_rec  = r_data_rec;
  assign bus.send_done = r_send_done;
  assign bus.rec_done  = r_rec_done;
  assign bus.busy      = r_busy;
  assign o_spi_cs_n    = r_cs_n;
  assign o_spi_sclk    = w_sclk;
  assign o_spi_mosi    = r_mosi;

endmodule

// File: tb/tb_spi_master_drive.sv
// Bench for spi_master_drive at CLK_DIV=2: cycle-sampled SPI slave model on the pins,
// table of single-byte transactions plus stream, misuse and mid-byte reset sequences.
module tb_spi_master_drive;
  import spi_master_drive_pkg::*;

  localparam int FIRST_RISE_LAT = 4;
  localparam int DONE_LAT       = 34;
  localparam int BYTE_PERIOD    = 33;
  localparam int CS_RISE_LAT    = 3;

  logic sys_clk = 1'b0;
  logic sys_rst_n = 1'b1;
  logic o_spi_cs_n, o_spi_sclk, o_spi_mosi;
  logic i_spi_miso = 1'b0;

  spi_master_drive_if bus();

  spi_master_drive #(.CLK_DIV(2)) dut (
    .sys_clk    (sys_clk),
    .sys_rst_n  (sys_rst_n),
    .bus        (bus.slave),
    .o_spi_cs_n (o_spi_cs_n),
    .o_spi_sclk (o_spi_sclk),
    .o_spi_mosi (o_spi_mosi),
    .i_spi_miso (i_spi_miso)
  );

  always #10 sys_clk = ~sys_clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d (0x%0h) required=%0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  // ---------------- slave model / monitor ----------------
  int cyc = 0;
  always @(posedge sys_clk) cyc <= cyc + 1;

  logic [7:0] slv_tx [4];
  int   slv_byte = 0, slv_bit = 0;
  logic prev_cs = 1'b1, prev_sclk = 1'b0;
  logic [7:0] mon_rx = '0;
  logic [7:0] slv_cur;
  int   rise_cnt = 0, t_first_rise = -1, t_cs_fall = 0, t_cs_rise = 0;
  int   cs_rise_cnt = 0, done_mismatch = 0;
  int   done_t_q[$];
  logic [7:0] done_mon_q[$];
  logic [7:0] done_rec_q[$];

  always @(negedge sys_clk) begin
    if (prev_cs && !o_spi_cs_n) begin
      t_cs_fall = cyc; rise_cnt = 0; t_first_rise = -1;
    end
    if (!prev_cs && o_spi_cs_n) begin
      t_cs_rise = cyc; cs_rise_cnt++;
    end
    if (o_spi_cs_n) begin
      slv_byte = 0; slv_bit = 0;
    end else begin
      if (o_spi_sclk && !prev_sclk) begin
        mon_rx = {mon_rx[6:0], o_spi_mosi};
        rise_cnt++;
        if (rise_cnt == 1) t_first_rise = cyc;
      end
      if (!o_spi_sclk && prev_sclk) begin
        slv_bit++;
        if (slv_bit == 8) begin slv_bit = 0; slv_byte++; end
      end
    end
    if (bus.send_done) begin
      done_t_q.push_back(cyc);
      done_mon_q.push_back(mon_rx);
      done_rec_q.push_back(bus.data_rec);
    end
    if (bus.send_done !== bus.rec_done) done_mismatch++;
    prev_cs   = o_spi_cs_n;
    prev_sclk = o_spi_sclk;
    slv_cur   = slv_tx[slv_byte % 4];
    i_spi_miso = slv_cur[7 - slv_bit];
  end

  // ---------------- driver helpers ----------------
  task automatic start_txn(input logic [7:0] b);
    @(posedge sys_clk); #1;
    bus.spi_start = 1'b1; bus.data_send = b;
    @(posedge sys_clk); #1;
    bus.spi_start = 1'b0;
  endtask

  task automatic wait_done(output bit ok);
    ok = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge sys_clk);
      if (bus.send_done) begin ok = 1; break; end
    end
  endtask

  task automatic wait_cs_high(output bit ok);
    ok = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge sys_clk);
      if (o_spi_cs_n) begin ok = 1; break; end
    end
  endtask

  task automatic wait_rises(input int n, output bit ok);
    ok = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge sys_clk); #1;
      if (rise_cnt >= n) begin ok = 1; break; end
    end
  endtask

  typedef struct {
    logic [7:0] tx;
    logic [7:0] slv;
    logic [7:0] exp_mosi;
    logic [7:0] exp_rec;
  } vec_t;

  vec_t vecs[4];

  task automatic run_single(input vec_t v, input string tag);
    int  q0;
    int  cr0;
    bit  ok;
    q0  = done_t_q.size();
    cr0 = cs_rise_cnt;
    slv_tx[0] = v.slv;
    start_txn(v.tx);
    wait_done(ok);
    check({tag, "_done_seen"}, int'(ok), 1);
    bus.spi_end = 1'b1;
    @(negedge sys_clk);
    bus.spi_end = 1'b0;
    wait_cs_high(ok);
    check({tag, "_cs_release"}, int'(ok), 1);
    repeat (2) @(negedge sys_clk);
    check({tag, "_done_count"}, done_t_q.size() - q0, 1);
    if (done_t_q.size() > q0) begin
      check({tag, "_mosi_byte"}, int'(done_mon_q[q0]), int'(v.exp_mosi));
      check({tag, "_data_rec"}, int'(done_rec_q[q0]), int'(v.exp_rec));
      check({tag, "_done_lat"}, done_t_q[q0] - t_cs_fall, DONE_LAT);
      check({tag, "_cs_rise_lat"}, t_cs_rise - done_t_q[q0], CS_RISE_LAT);
    end
    check({tag, "_first_rise_lat"}, t_first_rise - t_cs_fall, FIRST_RISE_LAT);
    check({tag, "_rise_count"}, rise_cnt, 8);
    check({tag, "_cs_rises"}, cs_rise_cnt - cr0, 1);
    check({tag, "_mosi_hold"}, int'(o_spi_mosi), int'(v.exp_mosi[0]));
    check({tag, "_rec_held"}, int'(bus.data_rec), int'(v.exp_rec));
    check({tag, "_busy_idle"}, int'(bus.busy), 0);
  endtask

  // ---------------- test sequence ----------------
  logic [7:0] strm_tx [4];
  logic [7:0] strm_rx [4];

  initial begin
    bit ok;
    int q0, cr0, d0;
    bus.spi_start = 1'b0;
    bus.spi_end   = 1'b0;
    bus.data_send = 8'h00;
    for (int i = 0; i < 4; i++) slv_tx[i] = 8'h00;

    vecs[0] = '{tx: 8'hA5, slv: 8'h3C, exp_mosi: 8'hA5, exp_rec: 8'h3C};
    vecs[1] = '{tx: 8'h00, slv: 8'hFF, exp_mosi: 8'h00, exp_rec: 8'hFF};
    vecs[2] = '{tx: 8'hFF, slv: 8'h00, exp_mosi: 8'hFF, exp_rec: 8'h00};
    vecs[3] = '{tx: 8'h81, slv: 8'h5A, exp_mosi: 8'h81, exp_rec: 8'h5A};

    // Reset values
    #5 sys_rst_n = 1'b0;
    repeat (3) @(negedge sys_clk);
    check("rst_cs_n", int'(o_spi_cs_n), 1);
    check("rst_sclk", int'(o_spi_sclk), 0);
    check("rst_mosi", int'(o_spi_mosi), 0);
    check("rst_data_rec", int'(bus.data_rec), 0);
    check("rst_busy", int'(bus.busy), 0);
    check("rst_send_done", int'(bus.send_done), 0);
    check("rst_rec_done", int'(bus.rec_done), 0);
    sys_rst_n = 1'b1;
    repeat (2) @(negedge sys_clk);

    // Single-byte table
    for (int i = 0; i < 4; i++) run_single(vecs[i], $sformatf("vec%0d", i));

    // Stream: READ opcode plus three address bytes, no gaps
    strm_tx = '{FLASH_READ, 8'h00, 8'h00, 8'h00};
    strm_rx = '{8'hC2, 8'h20, 8'h16, 8'h5A};
    for (int i = 0; i < 4; i++) slv_tx[i] = strm_rx[i];
    q0 = done_t_q.size(); cr0 = cs_rise_cnt;
    start_txn(strm_tx[0]);
    for (int k = 0; k < 4; k++) begin
      wait_done(ok);
      if (!ok) break;
      if (k < 3) begin
        bus.data_send = strm_tx[k + 1];
      end else begin
        bus.spi_end = 1'b1;
        @(negedge sys_clk);
        bus.spi_end = 1'b0;
      end
    end
    check("strm_done_seen", int'(ok), 1);
    wait_cs_high(ok);
    repeat (2) @(negedge sys_clk);
    check("strm_done_count", done_t_q.size() - q0, 4);
    check("strm_cs_rises", cs_rise_cnt - cr0, 1);
    check("strm_rise_count", rise_cnt, 32);
    if (done_t_q.size() - q0 == 4) begin
      for (int k = 0; k < 4; k++) begin
        check($sformatf("strm_mosi%0d", k), int'(done_mon_q[q0 + k]), int'(strm_tx[k]));
        check($sformatf("strm_rec%0d", k), int'(done_rec_q[q0 + k]), int'(strm_rx[k]));
        if (k > 0)
          check($sformatf("strm_gap%0d", k), done_t_q[q0 + k] - done_t_q[q0 + k - 1], BYTE_PERIOD);
      end
      check("strm_cs_rise_lat", t_cs_rise - done_t_q[q0 + 3], CS_RISE_LAT);
    end

    // Misuse: start while busy, end request mid byte 2
    slv_tx[0] = 8'hA7; slv_tx[1] = 8'h4E;
    q0 = done_t_q.size(); cr0 = cs_rise_cnt;
    start_txn(8'h9F);
    repeat (10) @(negedge sys_clk);
    bus.spi_start = 1'b1; bus.data_send = 8'h77;
    @(negedge sys_clk);
    bus.spi_start = 1'b0; bus.data_send = 8'h55;
    wait_done(ok);
    check("mis_done1_seen", int'(ok), 1);
    wait_rises(11, ok);
    check("mis_bit3_reached", int'(ok), 1);
    bus.spi_end = 1'b1;
    @(negedge sys_clk);
    bus.spi_end = 1'b0;
    wait_cs_high(ok);
    check("mis_cs_release", int'(ok), 1);
    repeat (2) @(negedge sys_clk);
    check("mis_done_count", done_t_q.size() - q0, 2);
    check("mis_cs_rises", cs_rise_cnt - cr0, 1);
    check("mis_rise_count", rise_cnt, 16);
    check("mis_busy_idle", int'(bus.busy), 0);
    if (done_t_q.size() - q0 == 2) begin
      check("mis_mosi0", int'(done_mon_q[q0]), 8'h9F);
      check("mis_rec0", int'(done_rec_q[q0]), 8'hA7);
      check("mis_mosi1", int'(done_mon_q[q0 + 1]), 8'h55);
      check("mis_rec1", int'(done_rec_q[q0 + 1]), 8'h4E);
      check("mis_done_lat", done_t_q[q0] - t_cs_fall, DONE_LAT);
      check("mis_gap", done_t_q[q0 + 1] - done_t_q[q0], BYTE_PERIOD);
      check("mis_cs_rise_lat", t_cs_rise - done_t_q[q0 + 1], CS_RISE_LAT);
    end

    // Reset in the middle of bit 5, SCLK high
    slv_tx[0] = 8'h96;
    start_txn(8'hC3);
    wait_rises(5, ok);
    check("rstmid_bit5_reached", int'(ok), 1);
    check("rstmid_sclk_before", int'(o_spi_sclk), 1);
    d0 = done_t_q.size();
    #1 sys_rst_n = 1'b0;
    #1;
    check("rstmid_cs_n", int'(o_spi_cs_n), 1);
    check("rstmid_sclk", int'(o_spi_sclk), 0);
    check("rstmid_busy", int'(bus.busy), 0);
    check("rstmid_mosi", int'(o_spi_mosi), 0);
    repeat (3) @(negedge sys_clk);
    check("rstmid_no_done", done_t_q.size() - d0, 0);
    sys_rst_n = 1'b1;
    repeat (2) @(negedge sys_clk);
    run_single(vecs[0], "post_rst");

    check("done_strobes_aligned", done_mismatch, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
